fpu_cmd_sequencer: RTL
======================

Name: fpu_cmd_sequencer

Overview:
Bus initiator that drives the FPU register block's addr/wren/wrdata/rddata/ack interface on behalf of a command producer, such as a test harness or a future wishbone-side queue.
Each accepted command runs the full register sequence: load operands, set rounding mode, pulse the OPERATION register, poll the read-clear done flag, then read back result and fflags.
The result is returned on a valid/ready response channel.
The block sits between the command source and the FPU register block, and is the only master of the register block when instantiated.

Parameters:
BASE_ADDR, 32'h3000_0000, base of FPU register map
IDLE_ADDR, 32'h0000_0000, address driven when no access is in progress; must decode to no register
TIMEOUT_CYCLES, 1024, max POLL cycles before abort; 0 disables timeout
TMO_W, 11, width of poll counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, single domain
rst_l  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_opa  in  32  operand A
cmd_opb  in  32  operand B
cmd_opc  in  32  operand C
cmd_op  in  13  OPERATION one-hot, bits [12:2] select the FPU operation
cmd_frm  in  3  rounding mode
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&&ready
rsp_result  out  32  RESULT register value
rsp_fflags  out  5  FFLAGS register value
rsp_timeout  out  1  poll aborted; result/fflags are 0
addr  out  32  register address
wren  out  1  1 = write, 0 = read
wrdata  out  32  write data
rddata  in  32  read data (combinational from addr)
ack  in  1  access complete this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_l=0):
  - State goes to IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_fflags=0, rsp_timeout=0.
  - addr=IDLE_ADDR, wren=0, wrdata=0, busy=0.
  - A reset mid-sequence abandons the command; no response is produced.
- Register offsets from BASE_ADDR: A=0x00, B=0x04, C=0x08, RESULT=0x0C, INTR=0x14, OPERATION=0x1C, FFLAGS=0x20, FCSR=0x28.
- Bus outputs are registered and decoded from state.
  - Each access state holds addr/wren/wrdata until the cycle ack=1 is sampled, then advances.
  - With the combinational-ack register block, each access completes in 1 cycle.
- IDLE:
  - cmd_ready=1 only in IDLE, and only when rsp_valid=0.
  - On handshake, opa/opb/opc/op/frm are latched into holding regs; next state is WR_A.
- Write states, in order; each is a write (wren=1) with the wrdata shown:
  - WR_A: opa
  - WR_B: opb
  - WR_C: opc
  - WR_FCSR: {24'b0, frm, 5'b0}; sets frm and clears accrued fflags
  - WR_OP: {19'b0, op}
  - CLR_OP: 32'b0; OPERATION is thus a pulse exactly one access long
- POLL:
  - Drives addr=INTR, wren=0.
  - Done when ack && rddata[0]; the register block clears the flag on this read, and the next state is RD_RES.
  - The poll counter increments every POLL cycle without done.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without done: go to RESP with rsp_timeout=1 and result/fflags=0.
  - The counter clears on entry to POLL.
- RD_RES: read RESULT; on ack, capture rddata into rsp_result.
- RD_FLG: read FFLAGS; on ack, capture rddata[4:0] into rsp_fflags.
- RESP:
  - rsp_valid=1, bus held at IDLE_ADDR/wren=0.
  - Output values are stable while rsp_valid && !rsp_ready.
  - On handshake, rsp_valid drops next cycle and state goes to IDLE.
  - rsp_timeout is cleared on the next command accept.
- Minimum latency from cmd handshake to rsp_valid = 10 cycles: 6 writes, 1 poll, 2 reads, +1 to RESP.
- The INTR address is never driven outside POLL. This prevents unintended read-clear of the done flag.
- Write data for 13-bit and 3-bit fields is zero-extended; upper bits are always 0.
- cmd_* inputs are ignored outside the IDLE handshake; changing them mid-sequence has no effect.

Decomposition:
- Package fpu_seq_pkg:
  - register offset localparams (OFS_A … OFS_FCSR);
  - state enum (IDLE, WR_A, WR_B, WR_C, WR_FCSR, WR_OP, CLR_OP, POLL, RD_RES, RD_FLG, RESP);
  - op one-hot width constant (13).
- No sub-module; the timeout counter is inline.
- Bench reuses the real fpu_registers plus a behavioural FPU model asserting fpu_valids after N cycles.

Test Plan:
1. Add 1.0+2.0: opa=0x3F800000, opb=0x40000000, op=13'h0004, frm=0, FPU model returns 0x40400000 after 3 cycles → rsp_result=0x40400000, rsp_fflags=0, rsp_timeout=0; bus write trace A,B,C,FCSR=0x00,OP=0x0004,OP=0x0 in 6 consecutive cycles.
2. Exception path: model returns result 0x7F800000 with exceptions=5'b00101 → rsp_fflags=5'b00101; FCSR write data=0x60 for frm=3.
3. Timeout: TIMEOUT_CYCLES=16, model never completes → rsp_valid exactly 16 POLL cycles after entering POLL, rsp_timeout=1, result=0, INTR never read outside POLL.
4. Backpressure: rsp_ready=0 for 5 cycles → rsp_* stable, cmd_ready=0 throughout, second cmd accepted only after response handshake.
5. Async reset asserted during POLL → all outputs at reset values same cycle, addr=IDLE_ADDR; a new command after release completes normally.
6. Back-to-back 3 commands with cmd_valid held high → three responses in order, each result matching its operands, no lost done flags.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared constants, state encoding and command payload for the FPU command sequencer.
`timescale 1ns/1ps
package fpu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 13;
    localparam int unsigned FRM_W    = 3;
    localparam int unsigned FFLAGS_W = 5;

    // Register offsets relative to the register block base address
    localparam logic [31:0] OFS_A         = 32'h0000_0000;
    localparam logic [31:0] OFS_B         = 32'h0000_0004;
    localparam logic [31:0] OFS_C         = 32'h0000_0008;
    localparam logic [31:0] OFS_RESULT    = 32'h0000_000C;
    localparam logic [31:0] OFS_INTR      = 32'h0000_0014;
    localparam logic [31:0] OFS_OPERATION = 32'h0000_001C;
    localparam logic [31:0] OFS_FFLAGS    = 32'h0000_0020;
    localparam logic [31:0] OFS_FCSR      = 32'h0000_0028;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_C,
        WR_FCSR,
        WR_OP,
        CLR_OP,
        POLL,
        RD_RES,
        RD_FLG,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [DATA_W-1:0] opc;
        logic [OP_W-1:0]   op;
        logic [FRM_W-1:0]  frm;
    } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_sequencer.sv
// Bus initiator that runs one full FPU register sequence per accepted command
// and returns the result on a valid/ready response channel.
`timescale 1ns/1ps
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0]  IDLE_ADDR      = 32'h0000_0000,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter int unsigned  TMO_W          = 11
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DATA_W-1:0]   cmd_opa,
    input  logic [DATA_W-1:0]   cmd_opb,
    input  logic [DATA_W-1:0]   cmd_opc,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [FRM_W-1:0]    cmd_frm,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [FFLAGS_W-1:0] rsp_fflags,
    output logic                rsp_timeout,
    output logic [31:0]         addr,
    output logic                wren,
    output logic [DATA_W-1:0]   wrdata,
    input  logic [DATA_W-1:0]   rddata,
    input  logic                ack,
    output logic                busy
);

    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e           state_q, state_d;
    fpu_cmd_t             cmd_q, cmd_d, cmd_in;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 cmd_ready_d, busy_d;
    logic                 rsp_valid_d, rsp_timeout_d;
    logic [DATA_W-1:0]    rsp_result_d;
    logic [FFLAGS_W-1:0]  rsp_fflags_d;
    logic [31:0]          addr_d;
    logic                 wren_d;
    logic [DATA_W-1:0]    wrdata_d;
    logic                 poll_done_c;

    assign poll_done_c = ack && rddata[0];

    // Registers: FSM state, holding regs, poll counter and all registered outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            tmo_q       <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_fflags  <= '0;
            rsp_timeout <= 1'b0;
            addr        <= IDLE_ADDR;
            wren        <= 1'b0;
            wrdata      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            tmo_q       <= tmo_d;
            cmd_ready   <= cmd_ready_d;
            busy        <= busy_d;
            rsp_valid   <= rsp_valid_d;
            rsp_result  <= rsp_result_d;
            rsp_fflags  <= rsp_fflags_d;
            rsp_timeout <= rsp_timeout_d;
            addr        <= addr_d;
            wren        <= wren_d;
            wrdata      <= wrdata_d;
        end
    end

    // Next state, response capture, and bus outputs decoded from the next state
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        tmo_d         = tmo_q;
        rsp_valid_d   = rsp_valid;
        rsp_result_d  = rsp_result;
        rsp_fflags_d  = rsp_fflags;
        rsp_timeout_d = rsp_timeout;
        addr_d        = IDLE_ADDR;
        wren_d        = 1'b0;
        wrdata_d      = '0;

        cmd_in.opa = cmd_opa;
        cmd_in.opb = cmd_opb;
        cmd_in.opc = cmd_opc;
        cmd_in.op  = cmd_op;
        cmd_in.frm = cmd_frm;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d         = cmd_in;
                    rsp_timeout_d = 1'b0;
                    rsp_result_d  = '0;
                    rsp_fflags_d  = '0;
                    state_d       = WR_A;
                end
            end
            WR_A:    if (ack) state_d = WR_B;
            WR_B:    if (ack) state_d = WR_C;
            WR_C:    if (ack) state_d = WR_FCSR;
            WR_FCSR: if (ack) state_d = WR_OP;
            WR_OP:   if (ack) state_d = CLR_OP;
            CLR_OP: begin
                if (ack) begin
                    tmo_d   = '0;
                    state_d = POLL;
                end
            end
            POLL: begin
                if (poll_done_c) begin
                    state_d = RD_RES;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
                    rsp_timeout_d = 1'b1;
                    rsp_result_d  = '0;
                    rsp_fflags_d  = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RD_RES: begin
                if (ack) begin
                    rsp_result_d = rddata;
                    state_d      = RD_FLG;
                end
            end
            RD_FLG: begin
                if (ack) begin
                    rsp_fflags_d = rddata[FFLAGS_W-1:0];
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // INTR is only ever addressed from POLL so the read-clear flag is never lost
        case (state_d)
            WR_A: begin
                addr_d   = BASE_ADDR + OFS_A;
                wren_d   = 1'b1;
                wrdata_d = cmd_d.opa;
            end
            WR_B: begin
                addr_d   = BASE_ADDR + OFS_B;
                wren_d   = 1'b1;
                wrdata_d = cmd_d.opb;
            end
            WR_C: begin
                addr_d   = BASE_ADDR + OFS_C;
                wren_d   = 1'b1;
                wrdata_d = cmd_d.opc;
            end
            WR_FCSR: begin
                addr_d   = BASE_ADDR + OFS_FCSR;
                wren_d   = 1'b1;
                wrdata_d = DATA_W'({cmd_d.frm, 5'b0});
            end
            WR_OP: begin
                addr_d   = BASE_ADDR + OFS_OPERATION;
                wren_d   = 1'b1;
                wrdata_d = DATA_W'(cmd_d.op);
            end
            CLR_OP: begin
                addr_d   = BASE_ADDR + OFS_OPERATION;
                wren_d   = 1'b1;
                wrdata_d = '0;
            end
            POLL:   addr_d = BASE_ADDR + OFS_INTR;
            RD_RES: addr_d = BASE_ADDR + OFS_RESULT;
            RD_FLG: addr_d = BASE_ADDR + OFS_FFLAGS;
            default: ;
        endcase

        cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
        busy_d      = (state_d != IDLE);
    end

endmodule
